// File: rtl/packet_ddr_pkg.sv
// Shared definitions for the packet <-> DDR receive/transmit paths.
// Holds the receive FSM state encoding, bus widths, the default maximum
// packet length, the header length field position and a helper that maps
// a byte index inside a 256-bit word to its bit position.
package packet_ddr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      RECV,
      WR_DATA,
      WR_HDR,
      DROP
   } state_t;

   localparam int MAX_LEN_DEFAULT = 256;
   localparam int BYTES_PER_WORD  = 32;
   localparam int ADDR_W          = 25;
   localparam int WORD_W          = 256;
   localparam int LEN_W           = 11;
   localparam int HDR_LEN_HI      = 10;
   localparam int HDR_LEN_LO      = 0;

   // Byte j lands big-endian inside 32-bit lane j/4, so its LSB sits at
   // lane*32 + (3 - j%4)*8, which is exactly {j[4:2], ~j[1:0], 3'b000}.
   function automatic logic [7:0] byte_lsb(input logic [4:0] idx);
      return {idx[4:2], ~idx[1:0], 3'b000};
   endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Collects received bytes into one 256-bit DDR word.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the word (combined with wr_en, the new byte survives)
//   wr_en      : store byte_in at position index
//   byte_in    : received byte
//   index      : byte position 0..31 within the word
//   word       : assembled word, unused bytes read as zero
module rx_word_packer
   import packet_ddr_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [7:0]        byte_in,
   input  logic [4:0]        index,
   output logic [WORD_W-1:0] word
);

   logic [WORD_W-1:0] word_next;

   always_comb begin
      word_next = clear ? '0 : word;
      if (wr_en) begin
         word_next[byte_lsb(index) +: 8] = byte_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
      end else begin
         word <= word_next;
      end
   end

endmodule

// File: rtl/receive_packet_ddr.sv
// Receives one packet from the TSE receive stream and stores it in DDR:
// data words go to start_ram_addr+1 onwards, then a length header is
// written to start_ram_addr. The header is always the last write, so an
// aborted or errored packet never leaves a valid header behind.
// Ports:
//   clk_original, rst_n           : clock, asynchronous active-low reset
//   cmd_recv, start_ram_addr      : arm request and header word address
//   ff_rx_*                       : TSE receive stream, ff_rx_rdy is our ready
//   ram_address/wdata/wren/ack    : word write request with ack handshake
//   busy, pkt_done, pkt_err       : status, done/err are 1-cycle pulses
//   pkt_len                       : last completed or dropped length
module receive_packet_ddr
   import packet_ddr_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic              clk_original,
   input  logic              rst_n,
   input  logic              cmd_recv,
   input  logic [ADDR_W-1:0] start_ram_addr,
   input  logic [7:0]        ff_rx_data,
   input  logic              ff_rx_dval,
   input  logic              ff_rx_sop,
   input  logic              ff_rx_eop,
   input  logic              ff_rx_err,
   output logic              ff_rx_rdy,
   output logic [ADDR_W-1:0] ram_address,
   output logic [WORD_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic              ram_ack,
   output logic              busy,
   output logic              pkt_done,
   output logic              pkt_err,
   output logic [LEN_W-1:0]  pkt_len
);

   localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
   localparam logic [4:0]       LAST_BYTE_C = 5'(BYTES_PER_WORD - 1);

   state_t              state, state_next;
   logic [ADDR_W-1:0]   base_addr;
   logic [ADDR_W-1:0]   data_ptr;
   logic [LEN_W-1:0]    count;
   logic [LEN_W-1:0]    cnt_plus;
   logic                last_word;
   logic                hdr_go;
   logic [WORD_W-1:0]   packed_word;

   logic accept, do_arm, pk_wr, pk_clear, cnt_inc, last_set, ptr_inc;
   logic done_set, err_end;

   assign ff_rx_rdy = (state == ARMED) || (state == RECV) || (state == DROP);
   assign busy      = (state != IDLE);
   assign accept    = ff_rx_rdy && ff_rx_dval;
   assign cnt_plus  = (count == '1) ? count : count + 1'b1;

   // The header request waits one cycle after WR_HDR is entered, so wren
   // always drops for a cycle between the final data ack and the header.
   assign ram_wren  = (state == WR_DATA) || ((state == WR_HDR) && hdr_go);

   always_ff @(posedge clk_original or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DROP itself is the sticky error condition: once
   // there, the packet can only end with an error pulse.
   always_comb begin
      state_next = state;
      do_arm     = 1'b0;
      pk_wr      = 1'b0;
      pk_clear   = 1'b0;
      cnt_inc    = 1'b0;
      last_set   = 1'b0;
      ptr_inc    = 1'b0;
      done_set   = 1'b0;
      err_end    = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_recv) begin
               do_arm     = 1'b1;
               pk_clear   = 1'b1;
               state_next = ARMED;
            end
         end
         ARMED: begin
            if (accept && ff_rx_sop) begin
               pk_wr   = 1'b1;
               cnt_inc = 1'b1;
               if (ff_rx_eop) begin
                  if (ff_rx_err) begin
                     err_end    = 1'b1;
                     state_next = IDLE;
                  end else begin
                     last_set   = 1'b1;
                     state_next = WR_DATA;
                  end
               end else begin
                  state_next = RECV;
               end
            end
         end
         RECV: begin
            if (accept) begin
               cnt_inc = 1'b1;
               if (ff_rx_sop || (count == MAX_LEN_C)) begin
                  if (ff_rx_eop) begin
                     err_end    = 1'b1;
                     state_next = IDLE;
                  end else begin
                     state_next = DROP;
                  end
               end else begin
                  pk_wr = 1'b1;
                  if (ff_rx_eop) begin
                     if (ff_rx_err) begin
                        err_end    = 1'b1;
                        state_next = IDLE;
                     end else begin
                        last_set   = 1'b1;
                        state_next = WR_DATA;
                     end
                  end else if (count[4:0] == LAST_BYTE_C) begin
                     state_next = WR_DATA;
                  end
               end
            end
         end
         WR_DATA: begin
            if (ram_ack) begin
               ptr_inc    = 1'b1;
               pk_clear   = 1'b1;
               state_next = last_word ? WR_HDR : RECV;
            end
         end
         WR_HDR: begin
            if (ram_ack && hdr_go) begin
               done_set   = 1'b1;
               state_next = IDLE;
            end
         end
         DROP: begin
            if (accept) begin
               cnt_inc = 1'b1;
               if (ff_rx_eop) begin
                  err_end    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Address, count and status registers. Status pulses are registered so
   // they appear in the first IDLE cycle after the packet finishes.
   always_ff @(posedge clk_original or negedge rst_n) begin
      if (!rst_n) begin
         base_addr <= '0;
         data_ptr  <= '0;
         count     <= '0;
         last_word <= 1'b0;
         hdr_go    <= 1'b0;
         pkt_done  <= 1'b0;
         pkt_err   <= 1'b0;
         pkt_len   <= '0;
      end else begin
         pkt_done <= done_set;
         pkt_err  <= err_end;
         hdr_go   <= (state == WR_HDR) && !done_set;
         if (do_arm) begin
            base_addr <= start_ram_addr;
            data_ptr  <= start_ram_addr + 1'b1;
            count     <= '0;
            last_word <= 1'b0;
            pkt_len   <= '0;
         end
         if (cnt_inc)  count     <= cnt_plus;
         if (last_set) last_word <= 1'b1;
         if (ptr_inc)  data_ptr  <= data_ptr + 1'b1;
         if (done_set) pkt_len   <= count;
         if (err_end)  pkt_len   <= cnt_plus;
      end
   end

   // Write bus is zero whenever no request is pending, including in reset.
   always_comb begin
      ram_address = '0;
      ram_wdata   = '0;
      if (state == WR_DATA) begin
         ram_address = data_ptr;
         ram_wdata   = packed_word;
      end else if ((state == WR_HDR) && hdr_go) begin
         ram_address                       = base_addr;
         ram_wdata[HDR_LEN_HI:HDR_LEN_LO] = count;
      end
   end

   rx_word_packer u_packer (
      .clk     (clk_original),
      .rst_n   (rst_n),
      .clear   (pk_clear),
      .wr_en   (pk_wr),
      .byte_in (ff_rx_data),
      .index   (count[4:0]),
      .word    (packed_word)
   );

endmodule

// File: tb/tb_receive_packet_ddr.sv
// Self-checking bench for receive_packet_ddr. Expected DDR writes are queued
// when a packet is sent and compared by a memory responder on every cycle
// the write request is up; the entry is popped when the write is acked.
module tb_receive_packet_ddr;

   localparam int MAX = 256;

   logic         clk_original   = 1'b0;
   logic         rst_n          = 1'b1;
   logic         cmd_recv       = 1'b0;
   logic [24:0]  start_ram_addr = '0;
   logic [7:0]   ff_rx_data     = '0;
   logic         ff_rx_dval     = 1'b0;
   logic         ff_rx_sop      = 1'b0;
   logic         ff_rx_eop      = 1'b0;
   logic         ff_rx_err      = 1'b0;
   logic         ff_rx_rdy;
   logic [24:0]  ram_address;
   logic [255:0] ram_wdata;
   logic         ram_wren;
   logic         ram_ack        = 1'b0;
   logic         busy;
   logic         pkt_done;
   logic         pkt_err;
   logic [10:0]  pkt_len;

   typedef struct {
      logic [24:0]  addr;
      logic [255:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks    = 0;
   int  errors    = 0;
   int  ack_delay = 0;
   int  wait_cnt  = 0;
   bit  prev_ack  = 1'b0;

   receive_packet_ddr #(.MAX_LEN(MAX)) dut (
      .clk_original   (clk_original),
      .rst_n          (rst_n),
      .cmd_recv       (cmd_recv),
      .start_ram_addr (start_ram_addr),
      .ff_rx_data     (ff_rx_data),
      .ff_rx_dval     (ff_rx_dval),
      .ff_rx_sop      (ff_rx_sop),
      .ff_rx_eop      (ff_rx_eop),
      .ff_rx_err      (ff_rx_err),
      .ff_rx_rdy      (ff_rx_rdy),
      .ram_address    (ram_address),
      .ram_wdata      (ram_wdata),
      .ram_wren       (ram_wren),
      .ram_ack        (ram_ack),
      .busy           (busy),
      .pkt_done       (pkt_done),
      .pkt_err        (pkt_err),
      .pkt_len        (pkt_len)
   );

   always #5 clk_original = ~clk_original;

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byteAt(input int first, input int step, input int i);
      return 8'(first + step * i);
   endfunction

   // Builds each 32-bit lane by shifting bytes in from the right, so the
   // first byte of a lane ends up in its top bits.
   function automatic logic [255:0] modelWord(input int w, input int first, input int step, input int stored);
      logic [255:0] d;
      logic [31:0]  lane;
      int           idx;
      d = '0;
      for (int l = 0; l < 8; l++) begin
         lane = '0;
         for (int k = 0; k < 4; k++) begin
            idx  = w * 32 + 4 * l + k;
            lane = {lane[23:0], (idx < stored) ? byteAt(first, step, idx) : 8'h00};
         end
         d[32*l +: 32] = lane;
      end
      return d;
   endfunction

   task automatic pushWrite(input logic [24:0] addr, input logic [255:0] data);
      wr_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Memory responder: checks the held request against the queue head on
   // every cycle, acks after ack_delay stall cycles, then expects a gap.
   always @(negedge clk_original) begin
      if (!rst_n) begin
         ram_ack  = 1'b0;
         wait_cnt = 0;
         prev_ack = 1'b0;
      end else if (prev_ack) begin
         checkOutput("wren_gap", {255'd0, ram_wren}, 256'd0);
         ram_ack  = 1'b0;
         prev_ack = 1'b0;
         wait_cnt = 0;
      end else if (ram_wren) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", {231'd0, ram_address}, 256'h1FFFFFF);
         end else begin
            checkOutput("wr_addr", {231'd0, ram_address}, {231'd0, exp_q[0].addr});
            checkOutput("wr_data", ram_wdata, exp_q[0].data);
         end
         if (wait_cnt < ack_delay) begin
            checkOutput("rdy_stall", {255'd0, ff_rx_rdy}, 256'd0);
            wait_cnt++;
            ram_ack = 1'b0;
         end else begin
            ram_ack  = 1'b1;
            prev_ack = 1'b1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end else begin
         ram_ack  = 1'b0;
         wait_cnt = 0;
      end
   end

   // Called at a negedge; returns at the negedge after the beat is taken.
   task automatic sendByte(input logic [7:0] d, input logic sop, input logic eop, input logic err);
      int guard;
      guard      = 0;
      ff_rx_data = d;
      ff_rx_dval = 1'b1;
      ff_rx_sop  = sop;
      ff_rx_eop  = eop;
      ff_rx_err  = err;
      while (!ff_rx_rdy && guard < 2000) begin
         @(negedge clk_original);
         guard++;
      end
      if (guard >= 2000) checkOutput("rdy_timeout", 256'd0, 256'd1);
      @(negedge clk_original);
      ff_rx_dval = 1'b0;
      ff_rx_sop  = 1'b0;
      ff_rx_eop  = 1'b0;
      ff_rx_err  = 1'b0;
   endtask

   task automatic armDut(input logic [24:0] addr);
      @(negedge clk_original);
      cmd_recv       = 1'b1;
      start_ram_addr = addr;
      @(negedge clk_original);
      cmd_recv       = 1'b0;
      start_ram_addr = '0;
      checkOutput("armed_busy", {255'd0, busy}, 256'd1);
      // a second request while busy must not move the header address
      cmd_recv       = 1'b1;
      start_ram_addr = addr ^ 25'h1FFF;
      @(negedge clk_original);
      cmd_recv       = 1'b0;
      start_ram_addr = '0;
   endtask

   task automatic applyStimulus(input logic [24:0] addr, input int n, input int first,
                                input int step, input bit err_eop, input int junk);
      int nw;
      int lim;
      armDut(addr);
      if (!err_eop && n <= MAX) begin
         nw = (n + 31) / 32;
         for (int w = 0; w < nw; w++) pushWrite(addr + 25'(1 + w), modelWord(w, first, step, n));
         pushWrite(addr, {245'd0, 11'(n)});
      end else begin
         lim = (n - 1 < MAX) ? n - 1 : MAX;
         nw  = lim / 32;
         for (int w = 0; w < nw; w++) pushWrite(addr + 25'(1 + w), modelWord(w, first, step, n));
      end
      for (int j = 0; j < junk; j++) sendByte(8'hEE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         sendByte(byteAt(first, step, i), i == 0, i == n - 1, err_eop && (i == n - 1));
      end
   endtask

   task automatic waitResult(input bit exp_done, input int exp_len, input bit chk_len);
      int guard;
      guard = 0;
      while (!(pkt_done || pkt_err) && guard < 5000) begin
         @(negedge clk_original);
         guard++;
      end
      if (guard >= 5000) begin
         checkOutput("result_timeout", 256'd0, 256'd1);
      end else begin
         checkOutput("pkt_done", {255'd0, pkt_done}, {255'd0, exp_done});
         checkOutput("pkt_err", {255'd0, pkt_err}, {255'd0, !exp_done});
         if (chk_len) checkOutput("pkt_len", {245'd0, pkt_len}, 256'(exp_len));
         @(negedge clk_original);
         checkOutput("pulse_width", {255'd0, pkt_done | pkt_err}, 256'd0);
      end
      checkOutput("busy_idle", {255'd0, busy}, 256'd0);
      checkOutput("queue_empty", 256'(exp_q.size()), 256'd0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk_original);
      checkOutput("rst_rdy", {255'd0, ff_rx_rdy}, 256'd0);
      checkOutput("rst_wren", {255'd0, ram_wren}, 256'd0);
      checkOutput("rst_busy", {255'd0, busy}, 256'd0);
      checkOutput("rst_done", {255'd0, pkt_done}, 256'd0);
      checkOutput("rst_err", {255'd0, pkt_err}, 256'd0);
      checkOutput("rst_addr", {231'd0, ram_address}, 256'd0);
      checkOutput("rst_wdata", ram_wdata, 256'd0);
      checkOutput("rst_len", {245'd0, pkt_len}, 256'd0);
      rst_n = 1'b1;
      @(negedge clk_original);

      $display("[TB] 64-byte packet, immediate ack");
      ack_delay = 0;
      applyStimulus(25'h100, 64, 16, 1, 1'b0, 0);
      waitResult(1'b1, 64, 1'b1);

      $display("[TB] 33-byte packet after non-sop beats");
      applyStimulus(25'h200, 33, 0, 1, 1'b0, 2);
      waitResult(1'b1, 33, 1'b1);

      $display("[TB] 40-byte packet, ack delayed 5 cycles");
      ack_delay = 5;
      applyStimulus(25'h300, 40, 160, 7, 1'b0, 0);
      waitResult(1'b1, 40, 1'b1);
      ack_delay = 0;

      $display("[TB] 40-byte packet with error on eop");
      applyStimulus(25'h400, 40, 3, 5, 1'b1, 0);
      waitResult(1'b0, 40, 1'b1);

      $display("[TB] 300-byte oversize packet");
      applyStimulus(25'h500, 300, 0, 1, 1'b0, 0);
      waitResult(1'b0, 300, 1'b0);

      $display("[TB] reset during data write, then 1-byte packet");
      ack_delay = 1000;
      armDut(25'h600);
      pushWrite(25'h601, modelWord(0, 64, 1, 32));
      for (int i = 0; i < 32; i++) sendByte(byteAt(64, 1, i), i == 0, 1'b0, 1'b0);
      checkOutput("wrdata_entered", {255'd0, ram_wren}, 256'd1);
      @(negedge clk_original);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_wren", {255'd0, ram_wren}, 256'd0);
      checkOutput("mid_rst_rdy", {255'd0, ff_rx_rdy}, 256'd0);
      checkOutput("mid_rst_busy", {255'd0, busy}, 256'd0);
      checkOutput("mid_rst_addr", {231'd0, ram_address}, 256'd0);
      checkOutput("mid_rst_wdata", ram_wdata, 256'd0);
      exp_q.delete();
      ack_delay = 0;
      @(negedge clk_original);
      rst_n = 1'b1;
      @(negedge clk_original);
      applyStimulus(25'h600, 1, 171, 0, 1'b0, 0);
      waitResult(1'b1, 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/receive_packet_ddr.md
RECEIVE_PACKET_DDR -- requirements
Module: receive_packet_ddr

Interface
REQ-001 The module SHALL have parameter MAX_LEN, default 256, giving the maximum accepted packet length in bytes.
REQ-002 The module SHALL have port clk_original, input, 1 bit: the single clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port cmd_recv, input, 1 bit: arm request, sampled only in IDLE.
REQ-005 The module SHALL have port start_ram_addr, input, 25 bits: header word address, captured on arm.
REQ-006 The module SHALL have ports ff_rx_data (8 bits), ff_rx_dval, ff_rx_sop, ff_rx_eop and ff_rx_err (1 bit each), all inputs: TSE receive stream.
REQ-007 The module SHALL have port ff_rx_rdy, output, 1 bit: sink ready.
REQ-008 The module SHALL have ports ram_address (25 bits), ram_wdata (256 bits) and ram_wren (1 bit), all outputs: word write request.
REQ-009 The module SHALL have port ram_ack, input, 1 bit: write accepted.
REQ-010 The module SHALL have outputs busy, pkt_done and pkt_err (1 bit each) and pkt_len (11 bits): status.

Function
REQ-011 The FSM SHALL use states IDLE, ARMED, RECV, WR_DATA, WR_HDR and DROP.
REQ-012 IDLE: when cmd_recv=1, the FSM SHALL capture start_ram_addr, clear the count, set the data pointer to start_ram_addr+1 and go to ARMED; busy=0 only in IDLE.
REQ-013 A beat SHALL be accepted only in a cycle with ff_rx_rdy=1 and ff_rx_dval=1.
REQ-014 ff_rx_rdy SHALL be 1 in ARMED, RECV and DROP, and 0 otherwise.
REQ-015 ARMED: the FSM SHALL discard accepted beats without sop; an accepted beat with sop SHALL be stored as byte 0 and the FSM SHALL go to RECV, or, if eop is also set, complete as a 1-byte packet.
REQ-016 Packing: byte j of a word (j=0..31) SHALL go to ram_wdata[(j/4)*32 + 31 - 8*(j%4) -: 8], i.e. big-endian within each 32-bit lane; unused bytes SHALL be 0.
REQ-017 When the 32nd byte of a word is accepted without eop, the FSM SHALL go to WR_DATA and then return to RECV after the ack.
REQ-018 Accepted eop with no error SHALL go to WR_DATA to write the final (possibly partial) word, then to WR_HDR.
REQ-019 Accepted eop with ff_rx_err=1, or with the error flag already set, SHALL go to IDLE with a 1-cycle pkt_err pulse and no header write.
REQ-020 Write handshake: ram_wren, ram_address and ram_wdata SHALL be held stable until ram_ack=1; ram_wren SHALL be 0 in the next cycle and the data pointer SHALL increment by 1 on each data ack.
REQ-021 WR_HDR SHALL write ram_wdata = {245'd0, len[10:0]} to the captured start address; on ack the FSM SHALL go to IDLE with a 1-cycle pkt_done pulse in the following cycle.
REQ-022 pkt_len SHALL hold the last completed or dropped length until the next arm.
REQ-023 A byte accepted when count==MAX_LEN, or an sop seen in RECV, SHALL set the error flag and move the FSM to DROP.
REQ-024 DROP SHALL discard bytes until eop and then behave as REQ-019.
REQ-025 The header SHALL be written last, so that DDR never holds a valid header for partial data.
REQ-026 cmd_recv asserted while busy=1 SHALL be ignored.
REQ-027 Length arithmetic SHALL be 11-bit unsigned; the number of data words SHALL be ceil(len/32).

Reset
REQ-028 While rst_n=0 the FSM SHALL be in IDLE and ff_rx_rdy, ram_wren, busy, pkt_done and pkt_err SHALL be 0.
REQ-029 While rst_n=0, ram_address, ram_wdata, pkt_len and all counters SHALL be 0.
REQ-030 Reset asserted mid-write SHALL drop ram_wren immediately; no partial packet SHALL be resumed after reset.

Structure
REQ-031 Shared package packet_ddr_pkg SHALL hold the state enum, MAX_LEN default, BYTES_PER_WORD=32 and the header length field position [10:0], shared with the transmit side.
REQ-032 Byte-to-word packing SHALL live in sub-module rx_word_packer (byte in, index, clear; 256-bit word out).

Verification
REQ-033 The bench SHALL cover: start 0x100, 64-byte packet with ff_rx_rdy/ram_ack immediate -> data at 0x101 and 0x102, then header 0x040 at 0x100, then pkt_done.
REQ-034 The bench SHALL cover: 33-byte packet 0x00..0x20 -> word 2 = 0x20 in bits [31:24] with rest 0, header 33, 3 writes total.
REQ-035 The bench SHALL cover: ram_ack delayed 5 cycles -> ff_rx_rdy=0 and wren/data stable for 5 cycles, no bytes lost.
REQ-036 The bench SHALL cover: 40-byte packet with ff_rx_err on eop -> pkt_err pulse, no write to the start address, pkt_len=40.
REQ-037 The bench SHALL cover: 300-byte packet with MAX_LEN=256 -> DROP, pkt_err, at most 8 data writes, no header.
REQ-038 The bench SHALL cover: rst_n low during WR_DATA -> ram_wren=0 the same cycle; a re-armed 1-byte packet completes with header 1.
